// File: rtl/snake_core.sv
// snake_core: snake game engine, segment shift array, game FSM, pixel hits.
// Define SNAKE_WRAP_EN to wrap the head at the walls instead of ending the game.
module snake_core #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int CELL     = 20,
  parameter int GRID_W   = 30,
  parameter int GRID_H   = 22,
  parameter int ORG_X    = 20,
  parameter int ORG_Y    = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step,
  input  logic                         start,
  input  logic                         U,
  input  logic                         D,
  input  logic                         L,
  input  logic                         R,
  input  logic [9:0]                   pix_x,
  input  logic [8:0]                   pix_y,
  output logic                         pix_head,
  output logic                         pix_body,
  output logic                         pix_food,
  output logic [1:0]                   state,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         score_inc
);

  localparam int CW = $clog2(GRID_W);
  localparam int RW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PLACE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  // XOR with 1 gives the opposite direction
  typedef enum logic [1:0] {
    D_UP = 2'd0,
    D_DN = 2'd1,
    D_LT = 2'd2,
    D_RT = 2'd3
  } dir_e;

  state_e          state_q;
  dir_e            dir_q;
  dir_e            pend_q;
  logic [LW-1:0]   length_q;
  logic            score_q;
  logic            pix_head_q;
  logic            pix_body_q;
  logic            pix_food_q;
  logic [15:0]     lfsr_q;
  logic [CW-1:0]   food_col_q;
  logic [RW-1:0]   food_row_q;
  logic [CW-1:0]   seg_col_q [MAX_LEN];
  logic [RW-1:0]   seg_row_q [MAX_LEN];

  dir_e            req_dir;
  logic            req_vld;
  dir_e            dir_rev;
  logic [CW-1:0]   nh_col;
  logic [RW-1:0]   nh_row;
  logic            wall;
  logic            wall_kill;
  logic            self_hit;
  logic            eat;
  logic [15:0]     lfsr_d;
  logic [CW-1:0]   cand_col;
  logic [RW-1:0]   cand_row;
  logic            overlap;
  logic [CW-1:0]   px_col;
  logic            px_cv;
  logic [RW-1:0]   py_row;
  logic            py_rv;
  logic            hit_head;
  logic            hit_body;
  logic            hit_food;

  function automatic logic [CW-1:0] init_col(input int k);
    if (k < INIT_LEN) return CW'(GRID_W/2 - k);
    return '0;
  endfunction

  function automatic logic [RW-1:0] init_row(input int k);
    if (k < INIT_LEN) return RW'(GRID_H/2);
    return '0;
  endfunction

  assign dir_rev = dir_e'(dir_q ^ 2'b01);

  // Button decode, U beats D beats L beats R
  always_comb begin
    req_vld = 1'b1;
    req_dir = D_RT;
    if (U)      req_dir = D_UP;
    else if (D) req_dir = D_DN;
    else if (L) req_dir = D_LT;
    else if (R) req_dir = D_RT;
    else        req_vld = 1'b0;
  end

  // Candidate head cell, wrapped at the walls, with a wall flag
  always_comb begin
    nh_col = seg_col_q[0];
    nh_row = seg_row_q[0];
    wall   = 1'b0;
    unique case (pend_q)
      D_UP: begin
        if (seg_row_q[0] == '0) begin
          wall   = 1'b1;
          nh_row = RW'(GRID_H-1);
        end else begin
          nh_row = seg_row_q[0] - RW'(1);
        end
      end
      D_DN: begin
        if (seg_row_q[0] == RW'(GRID_H-1)) begin
          wall   = 1'b1;
          nh_row = '0;
        end else begin
          nh_row = seg_row_q[0] + RW'(1);
        end
      end
      D_LT: begin
        if (seg_col_q[0] == '0) begin
          wall   = 1'b1;
          nh_col = CW'(GRID_W-1);
        end else begin
          nh_col = seg_col_q[0] - CW'(1);
        end
      end
      D_RT: begin
        if (seg_col_q[0] == CW'(GRID_W-1)) begin
          wall   = 1'b1;
          nh_col = '0;
        end else begin
          nh_col = seg_col_q[0] + CW'(1);
        end
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_kill = 1'b0;
`else
  assign wall_kill = wall;
`endif

  // Self hit skips the tail, which moves out of the way this step
  always_comb begin
    self_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((k + 2 <= int'(length_q)) &&
          seg_col_q[k] == nh_col &&
          seg_row_q[k] == nh_row)
        self_hit = 1'b1;
    end
  end

  assign eat = (nh_col == food_col_q) &&
               (nh_row == food_row_q);

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^
                   lfsr_q[3] ^ lfsr_q[5],
                   lfsr_q[15:1]};

  assign cand_col = CW'(lfsr_d[7:0] % 8'(GRID_W));
  assign cand_row = RW'(lfsr_d[15:8] % 8'(GRID_H));

  // Food candidate rejected if it lands on any live segment
  always_comb begin
    overlap = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k < int'(length_q)) &&
          seg_col_q[k] == cand_col &&
          seg_row_q[k] == cand_row)
        overlap = 1'b1;
    end
  end

  // Raster x to playfield column
  always_comb begin
    px_col = '0;
    px_cv  = 1'b0;
    for (int i = 0; i < GRID_W; i++) begin
      if (32'(pix_x) >= 32'(ORG_X + i*CELL)) begin
        px_col = CW'(i);
        px_cv  = 1'b1;
      end
    end
    if (32'(pix_x) >= 32'(ORG_X + GRID_W*CELL))
      px_cv = 1'b0;
  end

  // Raster y to playfield row
  always_comb begin
    py_row = '0;
    py_rv  = 1'b0;
    for (int i = 0; i < GRID_H; i++) begin
      if (32'(pix_y) >= 32'(ORG_Y + i*CELL)) begin
        py_row = RW'(i);
        py_rv  = 1'b1;
      end
    end
    if (32'(pix_y) >= 32'(ORG_Y + GRID_H*CELL))
      py_rv = 1'b0;
  end

  // Compare the raster cell against head, live body and food
  always_comb begin
    hit_head = 1'b0;
    hit_body = 1'b0;
    hit_food = 1'b0;
    if (px_cv && py_rv) begin
      hit_head = (seg_col_q[0] == px_col) &&
                 (seg_row_q[0] == py_row);
      hit_food = (food_col_q == px_col) &&
                 (food_row_q == py_row);
      for (int k = 1; k < MAX_LEN; k++) begin
        if ((k < int'(length_q)) &&
            seg_col_q[k] == px_col &&
            seg_row_q[k] == py_row)
          hit_body = 1'b1;
      end
    end
  end

  // Game FSM, segment array, food, LFSR and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dir_q      <= D_RT;
      pend_q     <= D_RT;
      length_q   <= LW'(INIT_LEN);
      score_q    <= 1'b0;
      pix_head_q <= 1'b0;
      pix_body_q <= 1'b0;
      pix_food_q <= 1'b0;
      lfsr_q     <= 16'hACE1;
      food_col_q <= CW'(GRID_W/2 + 5);
      food_row_q <= RW'(GRID_H/2);
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_col_q[k] <= init_col(k);
        seg_row_q[k] <= init_row(k);
      end
    end else begin
      score_q    <= 1'b0;
      pix_head_q <= hit_head;
      pix_body_q <= hit_body;
      pix_food_q <= hit_food;
      if (req_vld && req_dir != dir_rev)
        pend_q <= req_dir;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q  <= S_RUN;
            dir_q    <= D_RT;
            pend_q   <= D_RT;
            length_q <= LW'(INIT_LEN);
            for (int k = 0; k < MAX_LEN; k++) begin
              seg_col_q[k] <= init_col(k);
              seg_row_q[k] <= init_row(k);
            end
          end
        end
        S_RUN: begin
          if (step) begin
            dir_q <= pend_q;
            if (wall_kill || self_hit) begin
              state_q <= S_OVER;
            end else begin
              for (int k = MAX_LEN-1; k > 0; k--) begin
                seg_col_q[k] <= seg_col_q[k-1];
                seg_row_q[k] <= seg_row_q[k-1];
              end
              seg_col_q[0] <= nh_col;
              seg_row_q[0] <= nh_row;
              if (eat) begin
                if (length_q != LW'(MAX_LEN))
                  length_q <= length_q + LW'(1);
                score_q <= 1'b1;
                state_q <= S_PLACE;
              end
            end
          end
        end
        S_PLACE: begin
          lfsr_q <= lfsr_d;
          if (!overlap) begin
            food_col_q <= cand_col;
            food_row_q <= cand_row;
            state_q    <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign state     = state_q;
  assign length    = length_q;
  assign score_inc = score_q;
  assign pix_head  = pix_head_q;
  assign pix_body  = pix_body_q;
  assign pix_food  = pix_food_q;

endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: directed bench for snake_core.
// Expected positions are hand-derived from the default 30x22 grid.
module tb_snake_core;

  localparam int CELL  = 20;
  localparam int ORG_X = 20;
  localparam int ORG_Y = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step;
  logic       start;
  logic       U;
  logic       D;
  logic       L;
  logic       R;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_head;
  logic       pix_body;
  logic       pix_food;
  logic [1:0] state;
  logic [5:0] length;
  logic       score_inc;

  int checks = 0;
  int errors = 0;

  logic [3:0] chase [4];

  snake_core #(
    .MAX_LEN(32), .INIT_LEN(4), .CELL(CELL),
    .GRID_W(30), .GRID_H(22),
    .ORG_X(ORG_X), .ORG_Y(ORG_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .step(step), .start(start),
    .U(U), .D(D), .L(L), .R(R),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_head(pix_head), .pix_body(pix_body),
    .pix_food(pix_food), .state(state),
    .length(length), .score_inc(score_inc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic mv();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic btn(input logic [3:0] udlr);
    {U, D, L, R} = udlr;
    tick();
    {U, D, L, R} = 4'b0000;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic probe_px(input string tag,
                          input int x, input int y,
                          input logic eh,
                          input logic eb,
                          input logic ef);
    pix_x = 10'(x);
    pix_y = 9'(y);
    tick();
    chk({tag, ".head"}, 32'(pix_head), 32'(eh));
    chk({tag, ".body"}, 32'(pix_body), 32'(eb));
    chk({tag, ".food"}, 32'(pix_food), 32'(ef));
  endtask

  task automatic probe(input string tag,
                       input int c, input int r,
                       input logic eh,
                       input logic eb,
                       input logic ef);
    probe_px(tag, ORG_X + c*CELL, ORG_Y + r*CELL,
             eh, eb, ef);
  endtask

  initial begin
    chase[0] = 4'b0010;
    chase[1] = 4'b0100;
    chase[2] = 4'b0001;
    chase[3] = 4'b1000;
    rst_n = 1'b0;
    step  = 1'b0;
    start = 1'b0;
    {U, D, L, R} = 4'b0000;
    pix_x = '0;
    pix_y = '0;
    #12;
    chk("rst.state", 32'(state), 0);
    chk("rst.len", 32'(length), 4);
    chk("rst.score", 32'(score_inc), 0);
    chk("rst.pix", 32'({pix_head, pix_body, pix_food}), 0);
    rst_n = 1'b1;

    probe("idle.c15", 15, 11, 1, 0, 0);
    probe("idle.c12", 12, 11, 0, 1, 0);
    probe("idle.c11", 11, 11, 0, 0, 0);
    probe("idle.food", 20, 11, 0, 0, 1);

    go();
    chk("start.state", 32'(state), 1);
    repeat (3) mv();
    chk("run3.state", 32'(state), 1);
    chk("run3.len", 32'(length), 4);
    probe("run3.head", 18, 11, 1, 0, 0);
    probe("run3.seg1", 17, 11, 0, 1, 0);
    probe_px("px.left", 379, 240, 0, 1, 0);
    probe_px("px.lastin", 399, 259, 1, 0, 0);
    probe_px("px.rightout", 400, 240, 0, 0, 0);
    probe_px("px.botout", 380, 260, 0, 0, 0);
    probe_px("px.foodleft", 419, 240, 0, 0, 0);
    probe_px("px.foodin", 420, 240, 0, 0, 1);

    go();
    chk("runstart.state", 32'(state), 1);
    probe("runstart.head", 18, 11, 1, 0, 0);

    btn(4'b0010);
    mv();
    probe("rev.head", 19, 11, 1, 0, 0);
    btn(4'b1100);
    mv();
    probe("ud.head", 19, 10, 1, 0, 0);
    probe("ud.body", 19, 11, 0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      btn(chase[i % 4]);
      mv();
      chk("chase.state", 32'(state), 1);
    end
    chk("chase.len", 32'(length), 4);
    probe("chase.head", 19, 10, 1, 0, 0);
    probe("chase.tail", 18, 10, 0, 1, 0);

    rst_pulse();
    go();
    repeat (4) mv();
    chk("pre.score", 32'(score_inc), 0);
    mv();
    chk("eat.state", 32'(state), 2);
    chk("eat.score", 32'(score_inc), 1);
    chk("eat.len", 32'(length), 5);
    tick();
    chk("place.state", 32'(state), 1);
    chk("place.score", 32'(score_inc), 0);
    probe("newfood", 22, 20, 0, 0, 1);
    probe("eat.head", 20, 11, 1, 0, 0);
    probe("eat.tail", 16, 11, 0, 1, 0);

    btn(4'b1000);
    mv();
    chk("self.u", 32'(state), 1);
    btn(4'b0010);
    mv();
    chk("self.l", 32'(state), 1);
    btn(4'b0100);
    mv();
    chk("self.state", 32'(state), 3);
    chk("self.len", 32'(length), 5);
    probe("self.head", 19, 10, 1, 0, 0);
    mv();
    chk("frozen.state", 32'(state), 3);
    probe("frozen.head", 19, 10, 1, 0, 0);
    go();
    chk("restart.state", 32'(state), 1);
    chk("restart.len", 32'(length), 4);
    probe("restart.head", 15, 11, 1, 0, 0);

    rst_pulse();
    pix_x = 10'(ORG_X + 20*CELL);
    pix_y = 9'(ORG_Y + 11*CELL);
    go();
    repeat (5) mv();
    chk("rplace.state", 32'(state), 2);
    chk("rplace.foodpix", 32'(pix_food), 1);
    rst_n = 1'b0;
    #1;
    chk("rplace.rst.state", 32'(state), 0);
    chk("rplace.rst.len", 32'(length), 4);
    chk("rplace.rst.score", 32'(score_inc), 0);
    chk("rplace.rst.pix",
        32'({pix_head, pix_body, pix_food}), 0);
    #1;
    rst_n = 1'b1;

    go();
    btn(4'b1000);
    mv();
    btn(4'b0001);
    repeat (14) mv();
    chk("edge.state", 32'(state), 1);
    probe("edge.head", 29, 10, 1, 0, 0);
    mv();
`ifdef SNAKE_WRAP_EN
    chk("wall.state", 32'(state), 1);
    probe("wall.head", 0, 10, 1, 0, 0);
    probe("wall.body", 29, 10, 0, 1, 0);
`else
    chk("wall.state", 32'(state), 3);
    probe("wall.head", 29, 10, 1, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
